// File: rtl/mod_crc_engine.sv
// mod_crc_engine: bit-serial USB CRC5/CRC16 generator and checker, LSB first.
// Ports: iclk/irst_n (sync active-low); istart/imode start a packet; idata/inbits/ilast/ivalid
//   stream beats, accepted when ivalid & oready; obusy, odone pulse, ocrc and ocrc_ok report results.
// Optional: define CRC_CHECK_EN to compare the final register against the USB residual on ocrc_ok.
module mod_crc_engine #(
  parameter int DATA_W = 8,
  parameter int NB_W   = 4
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic              istart,
  input  logic              imode,
  input  logic [DATA_W-1:0] idata,
  input  logic [NB_W-1:0]   inbits,
  input  logic              ilast,
  input  logic              ivalid,
  output logic              oready,
  output logic              obusy,
  output logic [15:0]       ocrc,
  output logic              odone,
  output logic              ocrc_ok
);

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;

  localparam logic [NB_W-1:0] NB_FULL = NB_W'(DATA_W);
  localparam logic [NB_W-1:0] NB_ONE  = NB_W'(1);

  state_t            state, state_nxt;
  logic              mode_q;
  logic              last_q;
  logic [DATA_W-1:0] data_q;
  logic [NB_W-1:0]   cnt_q;
  logic [15:0]       crc_q;
  logic [15:0]       crc_step;
  logic [NB_W-1:0]   nbits;
  logic              accept;
  logic              zero_len;

  // One bit of the reflected (right-shifting) CRC. CRC5 lives in [4:0], upper bits kept 0.
  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic m, input logic d);
    logic fb;
    fb = c[0] ^ d;
    if (m) crc_bit = (c >> 1) ^ (fb ? 16'hA001 : 16'h0000);
    else   crc_bit = {11'd0, (c[4:0] >> 1) ^ (fb ? 5'h14 : 5'h00)};
  endfunction

  function automatic logic [15:0] crc_final(input logic [15:0] c, input logic m);
    crc_final = m ? ~c : {11'd0, ~c[4:0]};
  endfunction

`ifdef CRC_CHECK_EN
  function automatic logic residual_ok(input logic [15:0] c, input logic m);
    residual_ok = m ? (c == 16'hB001) : (c[4:0] == 5'h06);
  endfunction
`endif

  assign crc_step = crc_bit(crc_q, mode_q, data_q[0]);

  // Out-of-range or zero counts mean a full beat.
  assign nbits = ((inbits == '0) || (inbits > NB_FULL)) ? NB_FULL : inbits;

  always_ff @(posedge iclk) begin
    if (!irst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    oready    = 1'b0;
    obusy     = (state != IDLE);
    odone     = 1'b0;
    accept    = 1'b0;
    zero_len  = 1'b0;
    case (state)
      IDLE: begin
        if (istart) state_nxt = WAIT;
      end
      WAIT: begin
        oready = 1'b1;
        if (istart) begin
          state_nxt = WAIT;
        end else if (ivalid) begin
          accept = 1'b1;
          // inbits = 0 on the final beat is the empty-packet encoding.
          if (ilast && (inbits == '0)) begin
            zero_len  = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (istart)                 state_nxt = WAIT;
        else if (cnt_q == NB_ONE)   state_nxt = last_q ? DONE : WAIT;
      end
      DONE: begin
        odone     = 1'b1;
        state_nxt = istart ? WAIT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      crc_q  <= 16'hFFFF;
      mode_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
      ocrc   <= 16'h0000;
`ifdef CRC_CHECK_EN
      ocrc_ok <= 1'b0;
`endif
    end else if (istart) begin
      // Start (or abort-and-restart) from any state.
      mode_q <= imode;
      crc_q  <= imode ? 16'hFFFF : 16'h001F;
      ocrc   <= 16'h0000;
`ifdef CRC_CHECK_EN
      ocrc_ok <= 1'b0;
`endif
    end else begin
      if (accept) begin
        data_q <= idata;
        cnt_q  <= nbits;
        last_q <= ilast;
        if (zero_len) begin
          ocrc <= crc_final(crc_q, mode_q);
`ifdef CRC_CHECK_EN
          ocrc_ok <= residual_ok(crc_q, mode_q);
`endif
        end
      end
      if (state == SHIFT) begin
        crc_q  <= crc_step;
        data_q <= data_q >> 1;
        cnt_q  <= cnt_q - NB_ONE;
        // Result is registered on the last shift so it is valid with odone.
        if ((cnt_q == NB_ONE) && last_q) begin
          ocrc <= crc_final(crc_step, mode_q);
`ifdef CRC_CHECK_EN
          ocrc_ok <= residual_ok(crc_step, mode_q);
`endif
        end
      end
    end
  end

`ifndef CRC_CHECK_EN
  assign ocrc_ok = 1'b0;
`endif

endmodule

// File: tb/tb_mod_crc_engine.sv
`timescale 1ns/1ps
module tb_mod_crc_engine;
  localparam int DATA_W = 8;
  localparam int NB_W   = 4;

  logic        iclk = 1'b0;
  logic        irst_n, istart, imode, ilast, ivalid;
  logic [7:0]  idata;
  logic [3:0]  inbits;
  logic        oready, obusy, odone, ocrc_ok;
  logic [15:0] ocrc;

  mod_crc_engine #(.DATA_W(DATA_W), .NB_W(NB_W)) dut (
    .iclk(iclk), .irst_n(irst_n), .istart(istart), .imode(imode),
    .idata(idata), .inbits(inbits), .ilast(ilast), .ivalid(ivalid),
    .oready(oready), .obusy(obusy), .ocrc(ocrc), .odone(odone), .ocrc_ok(ocrc_ok)
  );

  always #5 iclk = ~iclk;

  int total = 0;
  int bad   = 0;

  // Activity monitor: counts odone pulses and SHIFT-looking cycles (busy, not ready, not done).
  int done_cnt     = 0;
  int shift_cycles = 0;
  bit prev_shift   = 0;
  bit done_after_shift = 0;
  always @(negedge iclk) begin
    if (odone === 1'b1) begin
      done_cnt++;
      done_after_shift = prev_shift;
    end
    prev_shift = (obusy === 1'b1) && (oready === 1'b0) && (odone === 1'b0);
    if (prev_shift) shift_cycles++;
  end

  // Packet under test.
  logic [7:0] b_dat[$];
  int         b_nb[$];

  // Results of the last drive_packet call.
  logic [15:0] r_crc, r_crc_next;
  bit          r_ok, r_after_shift, r_done_next, r_timeout;
  int          r_shifts, r_dones;

  // Reference: textbook MSB-first CRC over the wire bit sequence, reflected at the end.
  function automatic void model(input bit mode, output logic [15:0] crc, output bit ok, output int nb_total);
    int w, n;
    logic [15:0] poly, mask, r, refl;
    bit fb;
    w    = mode ? 16 : 5;
    poly = mode ? 16'h8005 : 16'h0005;
    mask = mode ? 16'hFFFF : 16'h001F;
    r    = mask;
    nb_total = 0;
    for (int i = 0; i < b_dat.size(); i++) begin
      n = b_nb[i];
      if (n == 0)      n = (i == b_dat.size() - 1) ? 0 : 8;
      else if (n > 8)  n = 8;
      for (int k = 0; k < n; k++) begin
        fb = r[w-1] ^ b_dat[i][k];
        r  = (r << 1) & mask;
        if (fb) r = r ^ poly;
      end
      nb_total += n;
    end
    refl = 16'h0000;
    for (int k = 0; k < w; k++) refl[k] = r[w-1-k];
    crc = ~refl & mask;
`ifdef CRC_CHECK_EN
    ok = mode ? (refl == 16'hB001) : (refl[4:0] == 5'h06);
`else
    ok = 1'b0;
`endif
  endfunction

  task automatic step();
    @(negedge iclk);
    #1;
  endtask

  task automatic load_ascii();
    b_dat.delete();
    b_nb.delete();
    for (int i = 0; i < 9; i++) begin
      b_dat.push_back(8'(8'h31 + i));
      b_nb.push_back(8);
    end
  endtask

  task automatic drive_packet(input bit do_start, input bit mode);
    int g, s0, d0;
    if (do_start) begin
      istart = 1'b1; imode = mode; ivalid = 1'b0;
      step();
      istart = 1'b0; imode = 1'($urandom);
    end
    s0 = shift_cycles; d0 = done_cnt; r_timeout = 1'b0;
    for (int i = 0; i < b_dat.size(); i++) begin
      idata  = b_dat[i];
      inbits = 4'(b_nb[i]);
      ilast  = (i == b_dat.size() - 1);
      ivalid = 1'b1;
      g = 0;
      while (oready !== 1'b1 && g < 100) begin step(); g++; end
      if (g >= 100) r_timeout = 1'b1;
      step();
    end
    ivalid = 1'b0; ilast = 1'b0; idata = 8'($urandom);
    g = 0;
    while (odone !== 1'b1 && g < 100) begin step(); g++; end
    if (odone !== 1'b1) r_timeout = 1'b1;
    r_crc = ocrc; r_ok = ocrc_ok; r_after_shift = done_after_shift;
    step();
    r_done_next = odone; r_crc_next = ocrc;
    r_shifts = shift_cycles - s0; r_dones = done_cnt - d0;
  endtask

  task automatic test_reset();
    irst_n = 1'b0; istart = 1'b0; imode = 1'b0; idata = 8'h00; inbits = 4'd0;
    ilast = 1'b0; ivalid = 1'b1;
    step(); step();
    total++; if (oready !== 1'b0) begin bad++; $display("FAIL reset_oready: got %b want 0", oready); end
    total++; if (obusy !== 1'b0) begin bad++; $display("FAIL reset_obusy: got %b want 0", obusy); end
    total++; if (odone !== 1'b0) begin bad++; $display("FAIL reset_odone: got %b want 0", odone); end
    total++; if (ocrc !== 16'h0000) begin bad++; $display("FAIL reset_ocrc: got %h want 0000", ocrc); end
    total++; if (ocrc_ok !== 1'b0) begin bad++; $display("FAIL reset_ocrc_ok: got %b want 0", ocrc_ok); end
    irst_n = 1'b1;
    step(); step(); step();
    total++; if (obusy !== 1'b0 || oready !== 1'b0) begin bad++; $display("FAIL idle_ignores_ivalid: busy=%b ready=%b want 0 0", obusy, oready); end
    ivalid = 1'b0;
  endtask

  task automatic test_crc5_token();
    b_dat.delete(); b_nb.delete();
    b_dat.push_back(8'h00); b_nb.push_back(8);
    b_dat.push_back(8'h00); b_nb.push_back(3);
    drive_packet(1'b1, 1'b0);
    total++; if (r_timeout) begin bad++; $display("FAIL crc5_token_timeout: got timeout want done"); end
    total++; if (r_crc !== 16'h0002) begin bad++; $display("FAIL crc5_token: got %h want 0002", r_crc); end
    total++; if (r_shifts !== 11) begin bad++; $display("FAIL crc5_token_shifts: got %0d want 11", r_shifts); end
    total++; if (r_done_next !== 1'b0 || r_dones !== 1) begin bad++; $display("FAIL crc5_token_pulse: next=%b count=%0d want 0 1", r_done_next, r_dones); end
    total++; if (r_crc_next !== 16'h0002) begin bad++; $display("FAIL crc5_token_hold: got %h want 0002", r_crc_next); end
  endtask

  task automatic test_crc16_ascii();
    load_ascii();
    drive_packet(1'b1, 1'b1);
    total++; if (r_crc !== 16'hB4C8) begin bad++; $display("FAIL crc16_ascii: got %h want b4c8", r_crc); end
    total++; if (r_shifts !== 72) begin bad++; $display("FAIL crc16_shifts: got %0d want 72", r_shifts); end
    total++; if (r_after_shift !== 1'b1) begin bad++; $display("FAIL crc16_latency: cycle before odone shift=%b want 1", r_after_shift); end
    total++; if (r_dones !== 1 || r_timeout) begin bad++; $display("FAIL crc16_done_count: got %0d (timeout=%b) want 1", r_dones, r_timeout); end
    total++; if (r_ok !== 1'b0) begin bad++; $display("FAIL crc16_ok_plain: got %b want 0", r_ok); end
  endtask

  task automatic test_crc5_ascii();
    load_ascii();
    drive_packet(1'b1, 1'b0);
    total++; if (r_crc !== 16'h0019) begin bad++; $display("FAIL crc5_ascii: got %h want 0019", r_crc); end
  endtask

  task automatic test_zero_length();
    b_dat.delete(); b_nb.delete();
    b_dat.push_back(8'hA7); b_nb.push_back(0);
    drive_packet(1'b1, 1'b1);
    total++; if (r_crc !== 16'h0000 || r_timeout) begin bad++; $display("FAIL zero_len_crc: got %h (timeout=%b) want 0000", r_crc, r_timeout); end
    total++; if (r_shifts !== 0 || r_dones !== 1) begin bad++; $display("FAIL zero_len_shape: shifts=%0d dones=%0d want 0 1", r_shifts, r_dones); end
  endtask

  task automatic test_residual();
    bit exp_ok;
`ifdef CRC_CHECK_EN
    exp_ok = 1'b1;
`else
    exp_ok = 1'b0;
`endif
    load_ascii();
    b_dat.push_back(8'hC8); b_nb.push_back(8);
    b_dat.push_back(8'hB4); b_nb.push_back(8);
    drive_packet(1'b1, 1'b1);
    total++; if (r_ok !== exp_ok) begin bad++; $display("FAIL residual_good: got %b want %b", r_ok, exp_ok); end
    b_dat[2] = b_dat[2] ^ 8'h08;
    drive_packet(1'b1, 1'b1);
    total++; if (r_ok !== 1'b0) begin bad++; $display("FAIL residual_corrupt: got %b want 0", r_ok); end
  endtask

  task automatic test_handshake();
    logic [15:0] ec; bit eo; int en;
    istart = 1'b1; imode = 1'b1; ivalid = 1'b1; idata = 8'h5A; inbits = 4'd8; ilast = 1'b1;
    step();
    istart = 1'b0; ivalid = 1'b0;
    total++; if (oready !== 1'b1) begin bad++; $display("FAIL start_with_valid: oready=%b want 1 (beat not taken)", oready); end
    b_dat.delete(); b_nb.delete();
    b_dat.push_back(8'hA5); b_nb.push_back(12);
    model(1'b1, ec, eo, en);
    drive_packet(1'b1, 1'b1);
    total++; if (r_shifts !== 8) begin bad++; $display("FAIL nbits_clamp_shifts: got %0d want 8", r_shifts); end
    total++; if (r_crc !== ec) begin bad++; $display("FAIL nbits_clamp_crc: got %h want %h", r_crc, ec); end
  endtask

  task automatic test_abort();
    int g, d0;
    istart = 1'b1; imode = 1'b1; step();
    istart = 1'b0;
    idata = 8'h31; inbits = 4'd8; ilast = 1'b0; ivalid = 1'b1;
    step();
    idata = 8'h32;
    g = 0;
    while (oready !== 1'b1 && g < 100) begin step(); g++; end
    step();
    ivalid = 1'b0;
    step(); step();
    total++; if (obusy !== 1'b1 || oready !== 1'b0) begin bad++; $display("FAIL abort_in_shift: busy=%b ready=%b want 1 0", obusy, oready); end
    d0 = done_cnt;
    istart = 1'b1; imode = 1'b1; step();
    istart = 1'b0;
    total++; if (oready !== 1'b1 || ocrc !== 16'h0000) begin bad++; $display("FAIL abort_restart: ready=%b ocrc=%h want 1 0000", oready, ocrc); end
    load_ascii();
    drive_packet(1'b0, 1'b1);
    total++; if (r_crc !== 16'hB4C8) begin bad++; $display("FAIL abort_then_clean: got %h want b4c8", r_crc); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    istart = 1'b1; imode = 1'b1; step();
    istart = 1'b0;
    idata = 8'h31; inbits = 4'd8; ilast = 1'b1; ivalid = 1'b1;
    step();
    ivalid = 1'b0;
    step(); step();
    d0 = done_cnt;
    irst_n = 1'b0;
    step();
    total++; if ({oready, obusy, odone, ocrc_ok} !== 4'b0000 || ocrc !== 16'h0000) begin
      bad++; $display("FAIL reset_mid_outputs: ready=%b busy=%b done=%b ok=%b crc=%h want all 0", oready, obusy, odone, ocrc_ok, ocrc);
    end
    irst_n = 1'b1;
    for (int i = 0; i < 15; i++) step();
    total++; if (done_cnt !== d0 || obusy !== 1'b0) begin bad++; $display("FAIL reset_mid_idle: dones=%0d busy=%b want 0 0", done_cnt - d0, obusy); end
    load_ascii();
    drive_packet(1'b1, 1'b1);
    total++; if (r_crc !== 16'hB4C8) begin bad++; $display("FAIL reset_mid_clean: got %h want b4c8", r_crc); end
  endtask

  task automatic test_random();
    logic [15:0] ec; bit eo; int en, nbeats; bit mode, app;
    for (int it = 0; it < 30; it++) begin
      mode   = 1'($urandom_range(0, 1));
      app    = 1'($urandom_range(0, 1));
      nbeats = $urandom_range(1, 4);
      b_dat.delete(); b_nb.delete();
      for (int i = 0; i < nbeats; i++) begin
        b_dat.push_back(8'($urandom));
        b_nb.push_back(app ? $urandom_range(1, 15) : $urandom_range(0, 15));
      end
      if (app) begin
        model(mode, ec, eo, en);
        if (mode) begin
          b_dat.push_back(ec[7:0]);  b_nb.push_back(8);
          b_dat.push_back(ec[15:8]); b_nb.push_back(8);
        end else begin
          b_dat.push_back({3'($urandom), ec[4:0]}); b_nb.push_back(5);
        end
      end
      model(mode, ec, eo, en);
      drive_packet(1'b1, mode);
      total++; if (r_crc !== ec || r_timeout) begin bad++; $display("FAIL rand_crc[%0d]: got %h (timeout=%b) want %h", it, r_crc, r_timeout, ec); end
      total++; if (r_ok !== eo) begin bad++; $display("FAIL rand_ok[%0d]: got %b want %b", it, r_ok, eo); end
      total++; if (r_shifts !== en || r_dones !== 1) begin bad++; $display("FAIL rand_shape[%0d]: shifts=%0d dones=%0d want %0d 1", it, r_shifts, r_dones, en); end
    end
  endtask

  initial begin
    test_reset();
    test_crc5_token();
    test_crc16_ascii();
    test_crc5_ascii();
    test_zero_length();
    test_residual();
    test_handshake();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
